// File: rtl/weight_in_ctrl_db_if.sv
// Weight stream valid/ready bundle.
// master drives IN_VALID/IN_DATA, slave returns IN_READY.
interface weight_in_ctrl_db_if #(
    parameter int INPUT_WIDTH = 32
);
    logic                   IN_VALID;
    logic                   IN_READY;
    logic [INPUT_WIDTH-1:0] IN_DATA;

    modport master (
        output IN_VALID,
        output IN_DATA,
        input  IN_READY
    );

    modport slave (
        input  IN_VALID,
        input  IN_DATA,
        output IN_READY
    );
endinterface

// File: rtl/weight_in_ctrl_db.sv
// Double-buffered weight loader: stream -> FIFO -> back bank, active bank -> MAC.
// Optional WEIGHT_IN_OVF_EN adds a sticky OVERFLOW flag for rejected beats.
module weight_in_ctrl_db #(
    parameter int INPUT_WIDTH = 32,
    parameter int ELEM_WIDTH  = 8,
    parameter int MAX_R       = 5,
    parameter int MAX_S       = 5,
    parameter int FIFO_DEPTH  = 16,
    parameter int CW          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              CLEAR,
    weight_in_ctrl_db_if.slave                STRM,
    output logic [CW-1:0]                     FIFO_COUNT,
    output logic                              FIFO_EMPTY,
    output logic                              FIFO_FULL,
    input  logic [3:0]                        PARAM_R,
    input  logic [3:0]                        PARAM_S,
    input  logic                              LOAD_START,
    output logic                              LOAD_BUSY,
    output logic                              LOAD_DONE,
    output logic                              PARAM_ERR,
    output logic                              BANK_READY,
    input  logic                              SWAP,
    output logic                              ACTIVE_BANK,
    output logic [MAX_R*MAX_S*ELEM_WIDTH-1:0] RD_DATA
`ifdef WEIGHT_IN_OVF_EN
    ,
    output logic                              OVERFLOW
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = MAX_R * MAX_S * ELEM_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ELEM_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  push;
    logic                  pop;
    logic [ELEM_WIDTH-1:0] pop_data;

    logic       ls_q;
    logic       rise;
    logic       legal;
    logic       start_ok;
    logic       start_bad;
    logic       swap_ok;
    logic       last;
    logic [3:0] r_q;
    logic [3:0] s_q;
    logic [3:0] row;
    logic [3:0] col;
    logic [15:0] widx;

    logic [BW-1:0] bank [2];
    logic [BW-1:0] rd_q;
    logic          bank_ready;
    logic          active;
    logic          param_err;

    // Only the low ELEM_WIDTH bits of a stream word carry the element.
    logic [INPUT_WIDTH-1:0] unused_data;
    assign unused_data = STRM.IN_DATA;

    assign FIFO_COUNT    = count;
    assign FIFO_EMPTY    = (count == '0);
    assign FIFO_FULL     = (count == CW'(FIFO_DEPTH));
    assign STRM.IN_READY = ~FIFO_FULL;

    // CLEAR drops a same-cycle push and freezes the loader.
    assign push     = STRM.IN_VALID & ~FIFO_FULL & ~CLEAR;
    assign pop      = (state == LOAD) & ~FIFO_EMPTY & ~CLEAR;
    assign pop_data = mem[rd_ptr];

    assign rise  = LOAD_START & ~ls_q;
    assign legal = (PARAM_R != 4'd0) && (int'(PARAM_R) <= MAX_R) &&
                   (PARAM_S != 4'd0) && (int'(PARAM_S) <= MAX_S);

    assign start_ok  = (state == IDLE) & rise & legal & ~CLEAR;
    assign start_bad = (state == IDLE) & rise & ~legal & ~CLEAR;
    // A simultaneous legal start wins over a swap so the back bank stays coherent.
    assign swap_ok   = (state == IDLE) & SWAP & bank_ready & ~CLEAR & ~start_ok;

    assign last = (row == r_q - 4'd1) && (col == s_q - 4'd1);
    assign widx = 16'(row) * 16'(MAX_S) + 16'(col);

    assign PARAM_ERR   = param_err;
    assign BANK_READY  = bank_ready;
    assign ACTIVE_BANK = active;
    assign RD_DATA     = rd_q;

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (CLEAR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= STRM.IN_DATA[ELEM_WIDTH-1:0];
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // LOAD_START history for rising-edge detection.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ls_q <= 1'b0;
        end else begin
            ls_q <= LOAD_START;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state;
        if (CLEAR) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok) state_nx = LOAD;
                LOAD:    if (pop && last) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        LOAD_BUSY = 1'b0;
        LOAD_DONE = 1'b0;
        case (state)
            LOAD:    LOAD_BUSY = 1'b1;
            DONE:    LOAD_DONE = 1'b1;
            default: ;
        endcase
    end

    // Load cursor, bank writes, bank ownership and error pulse.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_q        <= '0;
            s_q        <= '0;
            row        <= '0;
            col        <= '0;
            bank[0]    <= '0;
            bank[1]    <= '0;
            bank_ready <= 1'b0;
            active     <= 1'b0;
            param_err  <= 1'b0;
        end else begin
            param_err <= start_bad;
            if (CLEAR) begin
                row        <= '0;
                col        <= '0;
                bank_ready <= 1'b0;
            end else if (start_ok) begin
                r_q          <= PARAM_R;
                s_q          <= PARAM_S;
                row          <= '0;
                col          <= '0;
                bank[~active] <= '0;
                bank_ready   <= 1'b0;
            end else if (pop) begin
                bank[~active][widx*ELEM_WIDTH +: ELEM_WIDTH] <= pop_data;
                if (col == s_q - 4'd1) begin
                    col <= '0;
                    row <= row + 4'd1;
                end else begin
                    col <= col + 4'd1;
                end
                if (last) begin
                    bank_ready <= 1'b1;
                end
            end else if (swap_ok) begin
                active     <= ~active;
                bank_ready <= 1'b0;
            end
        end
    end

    // Registered view of the active bank for the MAC array.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_q <= '0;
        end else begin
            rd_q <= bank[active];
        end
    end

`ifdef WEIGHT_IN_OVF_EN
    // Sticky flag for beats offered while the FIFO is full.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            OVERFLOW <= 1'b0;
        end else if (CLEAR) begin
            OVERFLOW <= 1'b0;
        end else if (STRM.IN_VALID && FIFO_FULL) begin
            OVERFLOW <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_weight_in_ctrl_db.sv
// Directed bench for weight_in_ctrl_db.
// Expected values are hand-derived from the element sequences pushed.
module tb_weight_in_ctrl_db;

    localparam int EW = 8;
    localparam int MR = 5;
    localparam int MS = 5;
    localparam int BW = MR * MS * EW;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          CLEAR = 1'b0;
    logic          LOAD_START = 1'b0;
    logic          SWAP = 1'b0;
    logic [3:0]    PARAM_R = 4'd0;
    logic [3:0]    PARAM_S = 4'd0;
    logic [4:0]    FIFO_COUNT;
    logic          FIFO_EMPTY;
    logic          FIFO_FULL;
    logic          LOAD_BUSY;
    logic          LOAD_DONE;
    logic          PARAM_ERR;
    logic          BANK_READY;
    logic          ACTIVE_BANK;
    logic [BW-1:0] RD_DATA;
`ifdef WEIGHT_IN_OVF_EN
    logic          OVERFLOW;
`endif

    int checks = 0;
    int failures = 0;
    logic [BW-1:0] exp_stall;

    weight_in_ctrl_db_if #(.INPUT_WIDTH(32)) strm ();

    weight_in_ctrl_db dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .CLEAR       (CLEAR),
        .STRM        (strm),
        .FIFO_COUNT  (FIFO_COUNT),
        .FIFO_EMPTY  (FIFO_EMPTY),
        .FIFO_FULL   (FIFO_FULL),
        .PARAM_R     (PARAM_R),
        .PARAM_S     (PARAM_S),
        .LOAD_START  (LOAD_START),
        .LOAD_BUSY   (LOAD_BUSY),
        .LOAD_DONE   (LOAD_DONE),
        .PARAM_ERR   (PARAM_ERR),
        .BANK_READY  (BANK_READY),
        .SWAP        (SWAP),
        .ACTIVE_BANK (ACTIVE_BANK),
        .RD_DATA     (RD_DATA)
`ifdef WEIGHT_IN_OVF_EN
        ,
        .OVERFLOW    (OVERFLOW)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_seq(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            strm.IN_VALID = 1'b1;
            strm.IN_DATA  = {24'hA5A5A5, 8'(first + i)};
            tick();
        end
        strm.IN_VALID = 1'b0;
    endtask

    task automatic run(input int n, output int nb, output int nd);
        nb = 0;
        nd = 0;
        for (int i = 0; i < n; i++) begin
            nb += int'(LOAD_BUSY);
            nd += int'(LOAD_DONE);
            tick();
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({FIFO_COUNT, FIFO_EMPTY, FIFO_FULL, strm.IN_READY} !== {5'd0, 3'b101}) begin
            failures++;
            $display("FAIL reset_fifo got=%b exp=%b",
                     {FIFO_COUNT, FIFO_EMPTY, FIFO_FULL, strm.IN_READY}, 8'b00000101);
        end
        checks++;
        if ({LOAD_BUSY, LOAD_DONE, PARAM_ERR, BANK_READY, ACTIVE_BANK} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {LOAD_BUSY, LOAD_DONE, PARAM_ERR, BANK_READY, ACTIVE_BANK});
        end
        RESET = 1'b0;
        tick();
        checks++;
        if (RD_DATA !== '0) begin
            failures++;
            $display("FAIL reset_rd got=%h exp=0", RD_DATA);
        end
    endtask

    task automatic test_basic();
        int nb, nd;
        logic [BW-1:0] exp;
        push_seq(1, 9);
        checks++;
        if (FIFO_COUNT !== 5'd9) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=9", FIFO_COUNT);
        end
        PARAM_R = 4'd3;
        PARAM_S = 4'd3;
        LOAD_START = 1'b1;
        tick();
        LOAD_START = 1'b0;
        run(20, nb, nd);
        checks++;
        if (nb != 9 || nd != 1) begin
            failures++;
            $display("FAIL basic_busy_done got=%0d/%0d exp=9/1", nb, nd);
        end
        checks++;
        if (BANK_READY !== 1'b1 || FIFO_COUNT !== 5'd0) begin
            failures++;
            $display("FAIL basic_ready got=%b/%0d exp=1/0", BANK_READY, FIFO_COUNT);
        end
        SWAP = 1'b1;
        tick();
        SWAP = 1'b0;
        checks++;
        if (ACTIVE_BANK !== 1'b1 || BANK_READY !== 1'b0) begin
            failures++;
            $display("FAIL basic_swap got=%b/%b exp=1/0", ACTIVE_BANK, BANK_READY);
        end
        tick();
        exp = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                exp[(r*MS+c)*EW +: EW] = 8'(3*r + c + 1);
        checks++;
        if (RD_DATA !== exp) begin
            failures++;
            $display("FAIL basic_rd got=%h exp=%h", RD_DATA, exp);
        end
    endtask

    task automatic test_full();
        int nb, nd;
        logic [BW-1:0] exp;
        push_seq(8'h10, 16);
        checks++;
        if (FIFO_FULL !== 1'b1 || strm.IN_READY !== 1'b0 || FIFO_COUNT !== 5'd16) begin
            failures++;
            $display("FAIL full_flags got=%b/%b/%0d exp=1/0/16",
                     FIFO_FULL, strm.IN_READY, FIFO_COUNT);
        end
        strm.IN_VALID = 1'b1;
        strm.IN_DATA  = 32'h000000FF;
        tick();
        strm.IN_VALID = 1'b0;
        checks++;
        if (FIFO_COUNT !== 5'd16) begin
            failures++;
            $display("FAIL full_reject got=%0d exp=16", FIFO_COUNT);
        end
`ifdef WEIGHT_IN_OVF_EN
        checks++;
        if (OVERFLOW !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set got=%b exp=1", OVERFLOW);
        end
`endif
        PARAM_R = 4'd4;
        PARAM_S = 4'd4;
        LOAD_START = 1'b1;
        tick();
        LOAD_START = 1'b0;
        run(25, nb, nd);
        checks++;
        if (nb != 16 || nd != 1 || FIFO_COUNT !== 5'd0) begin
            failures++;
            $display("FAIL full_drain got=%0d/%0d/%0d exp=16/1/0", nb, nd, FIFO_COUNT);
        end
        SWAP = 1'b1;
        tick();
        SWAP = 1'b0;
        tick();
        exp = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                exp[(r*MS+c)*EW +: EW] = 8'(16 + 4*r + c);
        checks++;
        if (ACTIVE_BANK !== 1'b0 || RD_DATA !== exp) begin
            failures++;
            $display("FAIL full_rd got=%b/%h exp=0/%h", ACTIVE_BANK, RD_DATA, exp);
        end
`ifdef WEIGHT_IN_OVF_EN
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        checks++;
        if (OVERFLOW !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got=%b exp=0", OVERFLOW);
        end
`endif
    endtask

    task automatic test_param_err();
        int nb, nd;
        int rs[4] = '{0, 3, 6, 3};
        int ss[4] = '{3, 6, 3, 0};
        push_seq(8'h55, 1);
        PARAM_R = 4'd1;
        PARAM_S = 4'd1;
        LOAD_START = 1'b1;
        tick();
        LOAD_START = 1'b0;
        run(5, nb, nd);
        checks++;
        if (nd != 1 || BANK_READY !== 1'b1) begin
            failures++;
            $display("FAIL perr_setup got=%0d/%b exp=1/1", nd, BANK_READY);
        end
        for (int i = 0; i < 4; i++) begin
            PARAM_R = 4'(rs[i]);
            PARAM_S = 4'(ss[i]);
            LOAD_START = 1'b1;
            tick();
            checks++;
            if (PARAM_ERR !== 1'b1 || LOAD_BUSY !== 1'b0) begin
                failures++;
                $display("FAIL perr_pulse case=%0d got=%b/%b exp=1/0", i, PARAM_ERR, LOAD_BUSY);
            end
            LOAD_START = 1'b0;
            tick();
            checks++;
            if (PARAM_ERR !== 1'b0 || BANK_READY !== 1'b1 || LOAD_BUSY !== 1'b0) begin
                failures++;
                $display("FAIL perr_after case=%0d got=%b/%b/%b exp=0/1/0",
                         i, PARAM_ERR, BANK_READY, LOAD_BUSY);
            end
        end
    endtask

    task automatic test_stall();
        int nb, nd;
        push_seq(101, 10);
        PARAM_R = 4'd5;
        PARAM_S = 4'd5;
        LOAD_START = 1'b1;
        tick();
        LOAD_START = 1'b0;
        checks++;
        if (BANK_READY !== 1'b0 || LOAD_BUSY !== 1'b1) begin
            failures++;
            $display("FAIL stall_start got=%b/%b exp=0/1", BANK_READY, LOAD_BUSY);
        end
        run(15, nb, nd);
        checks++;
        if (nb != 15 || nd != 0 || FIFO_COUNT !== 5'd0) begin
            failures++;
            $display("FAIL stall_hold got=%0d/%0d/%0d exp=15/0/0", nb, nd, FIFO_COUNT);
        end
        push_seq(111, 15);
        run(10, nb, nd);
        checks++;
        if (nd != 1 || BANK_READY !== 1'b1) begin
            failures++;
            $display("FAIL stall_done got=%0d/%b exp=1/1", nd, BANK_READY);
        end
        SWAP = 1'b1;
        tick();
        SWAP = 1'b0;
        tick();
        exp_stall = '0;
        for (int k = 0; k < 25; k++)
            exp_stall[k*EW +: EW] = 8'(101 + k);
        checks++;
        if (ACTIVE_BANK !== 1'b1 || RD_DATA !== exp_stall) begin
            failures++;
            $display("FAIL stall_rd got=%b/%h exp=1/%h", ACTIVE_BANK, RD_DATA, exp_stall);
        end
    endtask

    task automatic test_clear();
        push_seq(8'hC0, 10);
        PARAM_R = 4'd5;
        PARAM_S = 4'd5;
        LOAD_START = 1'b1;
        tick();
        LOAD_START = 1'b0;
        repeat (6) tick();
        CLEAR = 1'b1;
        strm.IN_VALID = 1'b1;
        strm.IN_DATA  = 32'h77;
        tick();
        CLEAR = 1'b0;
        strm.IN_VALID = 1'b0;
        checks++;
        if (FIFO_COUNT !== 5'd0 || FIFO_EMPTY !== 1'b1 || LOAD_BUSY !== 1'b0) begin
            failures++;
            $display("FAIL clear_fifo got=%0d/%b/%b exp=0/1/0",
                     FIFO_COUNT, FIFO_EMPTY, LOAD_BUSY);
        end
        checks++;
        if (BANK_READY !== 1'b0 || ACTIVE_BANK !== 1'b1) begin
            failures++;
            $display("FAIL clear_bank got=%b/%b exp=0/1", BANK_READY, ACTIVE_BANK);
        end
        tick();
        checks++;
        if (RD_DATA !== exp_stall) begin
            failures++;
            $display("FAIL clear_rd got=%h exp=%h", RD_DATA, exp_stall);
        end
    endtask

    task automatic test_swap_ignore();
        SWAP = 1'b1;
        tick();
        SWAP = 1'b0;
        checks++;
        if (ACTIVE_BANK !== 1'b1) begin
            failures++;
            $display("FAIL swap_not_ready got=%b exp=1", ACTIVE_BANK);
        end
        PARAM_R = 4'd3;
        PARAM_S = 4'd3;
        LOAD_START = 1'b1;
        tick();
        LOAD_START = 1'b0;
        SWAP = 1'b1;
        tick();
        SWAP = 1'b0;
        checks++;
        if (ACTIVE_BANK !== 1'b1 || LOAD_BUSY !== 1'b1) begin
            failures++;
            $display("FAIL swap_busy got=%b/%b exp=1/1", ACTIVE_BANK, LOAD_BUSY);
        end
    endtask

    task automatic test_async_reset();
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if ({LOAD_BUSY, LOAD_DONE, PARAM_ERR, BANK_READY, ACTIVE_BANK} !== 5'b0) begin
            failures++;
            $display("FAIL areset_ctrl got=%b exp=00000",
                     {LOAD_BUSY, LOAD_DONE, PARAM_ERR, BANK_READY, ACTIVE_BANK});
        end
        checks++;
        if (RD_DATA !== '0 || FIFO_COUNT !== 5'd0 || FIFO_EMPTY !== 1'b1) begin
            failures++;
            $display("FAIL areset_data got=%h/%0d/%b exp=0/0/1",
                     RD_DATA, FIFO_COUNT, FIFO_EMPTY);
        end
        tick();
        RESET = 1'b0;
        tick();
    endtask

    initial begin
        strm.IN_VALID = 1'b0;
        strm.IN_DATA  = '0;
        test_reset();
        test_basic();
        test_full();
        test_param_err();
        test_stall();
        test_clear();
        test_swap_ignore();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
